// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result drain stage: FSM state encoding
// and index width calculation.
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

  // Index width for a dimension of size n, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_snapshot.sv
// Capture-enabled register bank holding one full result matrix; loads all
// elements on capture, holds otherwise, clears on asynchronous reset.
module result_snapshot #(
  parameter int W    = 16,
  parameter int ROWS = 2,
  parameter int COLS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic [W-1:0] result [ROWS][COLS],
  output logic [W-1:0] snap   [ROWS][COLS]
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          snap[r][c] <= '0;
        end
      end
    end else if (capture) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          snap[r][c] <= result[r][c];
        end
      end
    end
  end

endmodule

// File: rtl/result_drain.sv
// Waits LATENCY cycles after start, snapshots the result matrix and streams it
// row-major over valid/ready. Optional trailing sum beat: RESULT_DRAIN_CHECKSUM_EN.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int A_ROWS     = 2,
  parameter int B_COLS     = 2,
  parameter int LATENCY    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2*DATA_WIDTH-1:0]        result [A_ROWS][B_COLS],
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [2*DATA_WIDTH-1:0]        m_data,
  output logic [idx_width(A_ROWS)-1:0]   m_row,
  output logic [idx_width(B_COLS)-1:0]   m_col,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int DW    = 2 * DATA_WIDTH;
  localparam int ROW_W = idx_width(A_ROWS);
  localparam int COL_W = idx_width(B_COLS);
  localparam int LAT_W = idx_width(LATENCY);

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             done_q;
  logic             capture;
  logic             xfer;
  logic             elem_last;
  logic             elem_adv;
  logic             last_beat;
  logic [DW-1:0]    elem;
  logic [DW-1:0]    beat_data;
  logic [DW-1:0]    snap [A_ROWS][B_COLS];

  result_snapshot #(
    .W    (DW),
    .ROWS (A_ROWS),
    .COLS (B_COLS)
  ) u_snapshot (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .result  (result),
    .snap    (snap)
  );

  assign capture   = (state == WAIT) && (lat_cnt == '0);
  assign xfer      = m_valid && m_ready;
  assign elem      = snap[row][col];
  assign elem_last = (row == ROW_W'(A_ROWS - 1)) && (col == COL_W'(B_COLS - 1));

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic          sum_phase;
  logic [DW-1:0] sum_q;

  // Sum wraps naturally at DW bits; the extra beat follows the final element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      sum_phase <= 1'b0;
    end else if (capture) begin
      sum_q     <= '0;
      sum_phase <= 1'b0;
    end else if ((state == STREAM) && xfer) begin
      if (sum_phase) begin
        sum_phase <= 1'b0;
      end else begin
        sum_q <= sum_q + elem;
        if (elem_last) begin
          sum_phase <= 1'b1;
        end
      end
    end
  end

  assign last_beat = sum_phase;
  assign beat_data = sum_phase ? sum_q : elem;
  assign elem_adv  = xfer && !sum_phase;
`else
  assign last_beat = elem_last;
  assign beat_data = elem;
  assign elem_adv  = xfer;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = STREAM;
      STREAM:  if (xfer && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      lat_cnt <= LAT_W'(LATENCY - 1);
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Index returns to (0,0) after the final element so the sum beat and the
  // idle outputs both present row/col zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (capture) begin
      row <= '0;
      col <= '0;
    end else if ((state == STREAM) && elem_adv) begin
      if (elem_last) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_W'(B_COLS - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == STREAM) && xfer && last_beat;
    end
  end

  assign m_valid = (state == STREAM);
  assign m_data  = m_valid ? beat_data : '0;
  assign m_row   = row;
  assign m_col   = col;
  assign m_last  = m_valid && last_beat;
  assign busy    = (state != IDLE);
  assign done    = done_q;

endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the systolic matrix multiplier. It waits a fixed compute latency after `start`, snapshots the full `A_ROWS x B_COLS` result matrix presented by the array, and streams it out element by element in row-major order over a valid/ready interface. It frees the array for the next computation while the previous result is still draining.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: operand width; result elements are `2*DATA_WIDTH` bits.
- `A_ROWS`, default 2: result matrix rows.
- `B_COLS`, default 2: result matrix columns.
- `LATENCY`, default 8: cycles from accepted `start` to a valid result on `result`; legal range ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  pulse; same signal that drives the multiplier `enable`.
- `result`  in  `[2*DATA_WIDTH-1:0] [0:A_ROWS-1][0:B_COLS-1]`  systolic array outputs.
- `m_valid`  out  1  output element valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  `2*DATA_WIDTH`  output element.
- `m_row`  out  `$clog2(A_ROWS)` (min 1)  row index of `m_data`.
- `m_col`  out  `$clog2(B_COLS)` (min 1)  column index of `m_data`.
- `m_last`  out  1  final beat of the matrix.
- `busy`  out  1  high in WAIT or STREAM.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, WAIT, STREAM.
- IDLE: `start`=1 at an edge → WAIT, `lat_cnt` ← `LATENCY-1`.
- WAIT: `lat_cnt` decrements each cycle. At the edge where `lat_cnt`=0, all `result` elements are copied into the snapshot buffer, the index is set to (0,0), and the FSM goes to STREAM.
- STREAM: `m_valid`=1. `m_data` = `snap[row][col]`. A beat transfers on an edge with `m_valid && m_ready`.
  - After a transfer, `col` increments. At `B_COLS-1` it wraps to 0 and `row` increments.
  - After the transfer of the last beat, the FSM goes to IDLE and `done` pulses.
- `start` in WAIT or STREAM is ignored. There is no queuing.
- While `m_valid`=1 and `m_ready`=0, `m_data`, `m_row`, `m_col` and `m_last` hold stable.
- `m_last` is 1 only on the final beat (see Configuration).
- No arithmetic is done on elements. They pass through at full `2*DATA_WIDTH` width.
- Reset, asserted at any time including mid-stream, takes effect immediately:
  - FSM → IDLE.
  - Counters and index → 0.
  - Snapshot buffer → 0.
  - All outputs 0: `m_valid`, `m_data`, `m_row`, `m_col`, `m_last`, `busy`, `done`.
- `A_ROWS*B_COLS`=1: a single beat carries `m_last`=1 (non-checksum build).

## Timing
- `start` is sampled at edge T. The snapshot is taken at edge T+`LATENCY`. `m_valid` rises right after that edge.
- With `m_ready` held at 1, beats transfer at edges T+`LATENCY`+1 through T+`LATENCY`+N, where N = `A_ROWS*B_COLS` (+1 with checksum).
- `done` is high for the cycle after the last transfer edge. `busy` is low in that same cycle.
- A new `start` is accepted in the cycle `done` is high.
- Throughput with `m_ready` held at 1: one element per cycle, no bubbles.
- Outputs are registered or derived from state and registers only. There is no combinational path from `m_ready` to `m_valid`.

## Configuration
- Macro `RESULT_DRAIN_CHECKSUM_EN`.
- Defined:
  - The block keeps a running sum, modulo 2^(2*DATA_WIDTH), of all N elements.
  - After the final element it emits one extra beat with `m_data` = sum, `m_row`=0, `m_col`=0, `m_last`=1.
  - The last matrix element has `m_last`=0.
- Undefined:
  - No sum register is built.
  - `m_last`=1 on element (`A_ROWS-1`,`B_COLS-1`).

## Structure
- Package `result_drain_pkg` holds:
  - The state enum `drain_state_t` (IDLE, WAIT, STREAM).
  - Index width helper functions (`$clog2` with a minimum of 1).
- One sub-module, `result_snapshot`, is natural. It is the capture-enabled register bank with asynchronous reset, taking the `result` array in and giving `snap` out.
- The top of the block contains the FSM, the latency counter, the row/column index counter and the optional checksum accumulator.

## Test plan
- Matrices A=[[1,2],[3,4]], B=[[5,6],[7,8]], `LATENCY`=8, `m_ready`=1 → beats 19, 22, 43, 50 at (0,0), (0,1), (1,0), (1,1) on 4 consecutive cycles starting at T+9; `m_last` on 50; `done` at T+13.
- Same stimulus with `m_ready` toggling 1,0,0,1,… → each beat held stable while ready is low; the same 4 values arrive in order; no beat duplicated or dropped.
- With `RESULT_DRAIN_CHECKSUM_EN` defined, same stimulus → 5 beats; the fifth beat is 134 (0x0086) with `m_last`=1; beat 50 has `m_last`=0.
- Second `start` pulse during STREAM → ignored; exactly 4 beats; no WAIT entered until `done`; a `start` in the `done` cycle is accepted.
- `reset` pulsed mid-stream after beat 2 → all outputs 0 asynchronously; a fresh `start` yields a full 4-beat stream from (0,0).
- `A_ROWS`=`B_COLS`=1, `LATENCY`=1, `result`=0xFFFF → one beat 0xFFFF with `m_last`=1 at T+2; checksum build emits a second beat 0xFFFF with `m_last`=1.
